clock_display_scan: RTL

- Downstream consumer of the 12-hour BCD clock counter (pm, hh, mm, ss).
- Time-multiplexes six 7-segment digits (HH MM SS) plus a PM lamp onto a shared segment bus.
- Snapshots the time once per frame so that a frame never shows a mix of old and new digits.
- Blinks the colon dots on each rising edge of the counter's ena tick.

---
 rtl/clock_display_pkg.sv | 23 ++
 rtl/clock_display_scan_if.sv | 24 ++
 rtl/clock_display_scan_bcd_to_seg7.sv | 16 +
 rtl/clock_display_scan.sv | 106 ++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared types and constants for the clock display scanner.
// Optional dimming is enabled with `define CLOCK_DISPLAY_DIMMING_EN.
package clock_display_pkg;

  typedef enum logic [2:0] {
    DIG_SS_O = 3'd0,
    DIG_SS_T = 3'd1,
    DIG_MM_O = 3'd2,
    DIG_MM_T = 3'd3,
    DIG_HH_O = 3'd4,
    DIG_HH_T = 3'd5
  } digit_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [5:0] AN_OFF    = 6'b111111;

endpackage

// File: rtl/clock_display_scan_if.sv
// Time inputs from the clock counter and multiplexed display outputs.
// bright exists only when CLOCK_DISPLAY_DIMMING_EN is defined.
interface clock_display_scan_if;
  logic       ena;
  logic       pm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
`ifdef CLOCK_DISPLAY_DIMMING_EN
  logic [2:0] bright;
`endif
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       pm_led;

`ifdef CLOCK_DISPLAY_DIMMING_EN
  modport master (output ena, pm, hh, mm, ss, bright, input an, seg, dp, pm_led);
  modport slave  (input ena, pm, hh, mm, ss, bright, output an, seg, dp, pm_led);
`else
  modport master (output ena, pm, hh, mm, ss, input an, seg, dp, pm_led);
  modport slave  (input ena, pm, hh, mm, ss, output an, seg, dp, pm_led);
`endif
endinterface

// File: rtl/clock_display_scan_bcd_to_seg7.sv
// BCD nibble to 7-segment glyph; non-decimal nibbles show a dash.
module bcd_to_seg7
  import clock_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    for (int unsigned i = 0; i < 10; i++) begin
      if (nibble == 4'(i)) seg = SEG_DIGIT[i];
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit HH:MM:SS multiplexed 7-segment scanner with per-frame time snapshot.
// Optional per-slot PWM dimming is enabled with `define CLOCK_DISPLAY_DIMMING_EN.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 1000
)
(
  input logic           clk,
  input logic           reset,
  clock_display_scan_if.slave disp
);

  localparam int unsigned   CW   = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);

  logic [CW-1:0] cnt, cnt_next;
  digit_t        dig, dig_next;
  logic          pm_s, ena_q, phase;
  logic [7:0]    hh_s, mm_s, ss_s;
  logic          wrap, frame_wrap, ena_rise, slot_on, an_on, dp_next;
  logic [3:0]    nibble;
  logic [6:0]    glyph, seg_next;
  logic [5:0]    an_next;
`ifdef CLOCK_DISPLAY_DIMMING_EN
  logic [2:0]    bright_s;
`endif

  bcd_to_seg7 u_dec (
    .nibble(nibble),
    .seg   (glyph)
  );

  always_comb begin
    wrap       = (cnt == LAST);
    frame_wrap = wrap && (dig == DIG_HH_T);
    ena_rise   = disp.ena && !ena_q;
    cnt_next   = wrap ? '0 : cnt + CW'(1);
    dig_next   = dig;
    if (wrap) dig_next = (dig == DIG_HH_T) ? DIG_SS_O : digit_t'(dig + 3'd1);

    nibble = '0;
    case (dig)
      DIG_SS_O: nibble = ss_s[3:0];
      DIG_SS_T: nibble = ss_s[7:4];
      DIG_MM_O: nibble = mm_s[3:0];
      DIG_MM_T: nibble = mm_s[7:4];
      DIG_HH_O: nibble = hh_s[3:0];
      DIG_HH_T: nibble = hh_s[7:4];
      default:  nibble = '0;
    endcase

    // Count 0 of every slot is the ghost gap: anodes off, segments blank.
    slot_on = (cnt != '0);
`ifdef CLOCK_DISPLAY_DIMMING_EN
    an_on = slot_on && (cnt[2:0] <= bright_s);
`else
    an_on = slot_on;
`endif
    an_next = AN_OFF;
    if (an_on) an_next = AN_OFF & ~(6'b000001 << dig);

    seg_next = SEG_BLANK;
    if (slot_on && !(dig == DIG_HH_T && nibble == 4'd0)) seg_next = glyph;
    dp_next = slot_on && phase && (dig == DIG_MM_O || dig == DIG_HH_O);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      dig         <= DIG_SS_O;
      phase       <= 1'b1;
      ena_q       <= 1'b0;
      pm_s        <= 1'b0;
      hh_s        <= 8'h12;
      mm_s        <= '0;
      ss_s        <= '0;
`ifdef CLOCK_DISPLAY_DIMMING_EN
      bright_s    <= 3'd7;
`endif
      disp.an     <= AN_OFF;
      disp.seg    <= SEG_BLANK;
      disp.dp     <= 1'b0;
      disp.pm_led <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      dig   <= dig_next;
      ena_q <= disp.ena;
      if (ena_rise) phase <= ~phase;
      if (frame_wrap) begin
        pm_s     <= disp.pm;
        hh_s     <= disp.hh;
        mm_s     <= disp.mm;
        ss_s     <= disp.ss;
`ifdef CLOCK_DISPLAY_DIMMING_EN
        bright_s <= disp.bright;
`endif
      end
      disp.an     <= an_next;
      disp.seg    <= seg_next;
      disp.dp     <= dp_next;
      disp.pm_led <= pm_s;
    end
  end

endmodule
